// File: rtl/i2s_master_axis.sv
// I2S master: BCLK = ap_clk/(2*BCLK_DIV), 32-slot frames; record word valid 1 cycle after slot-0 rise.
// Playback accepts one word per frame on the wrap fall (missing -> underrun); unaccepted record word -> overrun.
module i2s_master_axis #(
    parameter int unsigned BCLK_DIV = 4
) (
    input  logic        ap_clk,
    input  logic        ap_rst_n,
    input  logic        enable,
    output logic        i2s_bclk,
    output logic        i2s_lrclk,
    output logic        i2s_sdout,
    input  logic        i2s_sdin,
    input  logic [31:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    input  logic        clear_status,
    output logic        underrun,
    output logic        overrun
);
    localparam logic [7:0] DIV_LAST = 8'(BCLK_DIV - 1);

    logic [7:0]  r_div;
    logic        r_bclk;
    logic [4:0]  r_bit_cnt;
    logic        r_sdout;
    logic [31:0] r_tx_word;
    logic [31:0] r_rx_shift;
    logic        r_sdin_q;
    logic        r_first;
    logic [31:0] r_m_dat;
    logic        r_m_vld;
    logic        r_underrun;
    logic        r_overrun;

    logic        w_tick;
    logic        w_rise;
    logic        w_fall;
    logic        w_wrap;
    logic        w_rx_done;
    logic        w_m_hs;
    logic        w_m_load;
    logic        w_set_ovr;
    logic        w_set_und;
    logic [31:0] w_rx_word;

    assign w_tick    = enable && (r_div == DIV_LAST);
    assign w_rise    = w_tick && !r_bclk;
    assign w_fall    = w_tick && r_bclk;
    assign w_wrap    = w_fall && (r_bit_cnt == 5'd31);
    assign w_rx_done = w_rise && (r_bit_cnt == 5'd0);
    assign w_rx_word = {r_rx_shift[30:0], r_sdin_q};
    assign w_m_hs    = r_m_vld && m_axis_tready;
    // The first word after a (re)start only holds the last two slots, so it is dropped.
    assign w_m_load  = w_rx_done && !r_first && (!r_m_vld || m_axis_tready);
    assign w_set_ovr = w_rx_done && !r_first && r_m_vld && !m_axis_tready;
    assign w_set_und = w_wrap && !s_axis_tvalid;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_div      <= '0;
            r_bclk     <= 1'b0;
            r_bit_cnt  <= 5'd31;
            r_sdout    <= 1'b0;
            r_tx_word  <= '0;
            r_rx_shift <= '0;
            r_sdin_q   <= 1'b0;
            r_first    <= 1'b1;
        end else begin
            r_sdin_q <= i2s_sdin;
            if (!enable) begin
                r_div      <= '0;
                r_bclk     <= 1'b0;
                r_bit_cnt  <= 5'd31;
                r_sdout    <= 1'b0;
                r_tx_word  <= '0;
                r_rx_shift <= '0;
                r_first    <= 1'b1;
            end else begin
                r_div <= w_tick ? '0 : r_div + 8'd1;
                if (w_tick) begin
                    r_bclk <= ~r_bclk;
                end
                // One-bit I2S delay: slot 0 still carries bit 0 of the previous word.
                if (w_fall) begin
                    r_bit_cnt <= r_bit_cnt + 5'd1;
                    if (w_wrap) begin
                        r_sdout   <= r_tx_word[0];
                        r_tx_word <= s_axis_tvalid ? s_axis_tdata : '0;
                    end else begin
                        r_sdout <= r_tx_word[5'd31 - r_bit_cnt];
                    end
                end
                if (w_rise) begin
                    r_rx_shift <= w_rx_word;
                end
                if (w_rx_done) begin
                    r_first <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_m_vld    <= 1'b0;
            r_m_dat    <= '0;
            r_underrun <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            if (w_m_load) begin
                r_m_vld <= 1'b1;
                r_m_dat <= w_rx_word;
            end else if (w_m_hs) begin
                r_m_vld <= 1'b0;
            end
            r_underrun <= w_set_und | (r_underrun & ~clear_status);
            r_overrun  <= w_set_ovr | (r_overrun & ~clear_status);
        end
    end

    assign i2s_bclk      = r_bclk;
    assign i2s_lrclk     = r_bit_cnt[4];
    assign i2s_sdout     = r_sdout;
    assign s_axis_tready = w_wrap;
    assign m_axis_tdata  = r_m_dat;
    assign m_axis_tvalid = r_m_vld;
    assign underrun      = r_underrun;
    assign overrun       = r_overrun;
endmodule
